sparse_act_expander: RTL and testbench
======================================

Name: sparse_act_expander

Overview:
- Decodes a compressed sparse activation vector into a dense activation stream for the ternary-weight neuron datapath.
- Input has two parts: an N-bit nonzero bitmap header, then a packed stream of only the nonzero 9-bit signed activations, in ascending index order.
- Emits N dense activations, one per handshake, with zeros reinserted at cleared bitmap positions. The output carries the index and a last flag.
- This is the decompressor counterpart of the neuron's bitmap/packed-element compression.

Parameters:
N, 20, activations per vector (bitmap width)
AW, 9, activation width (signed two's complement)
CW, 5, index/count width, = $clog2(N+1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  reset, synchronous, active-high
hdr_valid  input  1  bitmap header valid
hdr_ready  output  1  header accepted when hdr_valid && hdr_ready
hdr_bitmap  input  N  bit k=1 means activation k is nonzero and present in the nz stream
nz_valid  input  1  packed nonzero element valid
nz_ready  output  1  element consumed when nz_valid && nz_ready
nz_data  input  AW  signed nonzero activation value
out_valid  output  1  dense element valid (registered)
out_ready  input  1  downstream accepts
out_data  output  AW  signed dense activation (registered)
out_idx  output  CW  position 0..N-1 of out_data (registered)
out_last  output  1  high with the element at out_idx==N-1 (registered)
busy  output  1  state==EXPAND or out_valid

Behaviour:
- Reset (synchronous, active-high, clock clk): state=IDLE, pos=0, bitmap register=0, out_valid=0, out_data=0, out_idx=0, out_last=0. A partially consumed nz stream is not flushed; resynchronising it is the upstream's responsibility.
- Reset mid-vector aborts the vector. No further nz elements are consumed until a new header is accepted.
- hdr_ready = (state==IDLE) && !reset. It is combinational.
- FSM, two states:
  - IDLE: on header handshake, latch hdr_bitmap, set pos=0, go to EXPAND.
  - EXPAND: produce element at pos.
- load_en = !out_valid || out_ready.
- In EXPAND, the next element is available when bitmap[pos]==0, or when bitmap[pos]==1 && nz_valid.
- nz_ready = (state==EXPAND) && bitmap[pos] && load_en. It is combinational. No nz element is ever consumed for a zero position.
- On load_en && available:
  - out_valid<=1
  - out_data<= bitmap[pos] ? nz_data : 0
  - out_idx<=pos
  - out_last<=(pos==N-1)
  - pos<=pos+1
  - If pos==N-1: pos<=0, state<=IDLE on the same edge.
- If out_ready && !(new load), then out_valid<=0.
- out_data and out_idx hold stable while out_valid && !out_ready.
- Latency and throughput:
  - First dense element is registered 1 cycle after header accept.
  - Sustained 1 element/cycle when nz_valid and out_ready are held high.
  - Back-to-back vectors incur exactly 1 bubble cycle, spent in IDLE for the header accept.
- A header presented during EXPAND waits, since hdr_ready=0. hdr_bitmap is sampled only at its handshake.
- Boundaries:
  - All-zero bitmap: N zero outputs, nz_ready stays 0 throughout.
  - All-ones bitmap: exactly N nz elements consumed.
  - nz_valid low at a set position: stall without emitting.
  - Simultaneous out_ready and load: replace the register contents, out_valid stays 1.
- Signedness: nz_data is passed through unmodified. Zero insertion uses AW'sd0.

Optional Feature:
- Macro SPARSE_EXP_NNZ_EN.
- When defined:
  - Adds output nnz_count [CW-1:0], a registered popcount of hdr_bitmap latched at header accept (reset 0).
  - Adds output nz_err, a sticky flag (cleared only by reset). It is set if an nz element with nz_data==0 is consumed, which flags an encoder violation.
- When undefined, neither port exists and there is no popcount logic.

Decomposition:
- Package sparse_pkg:
  - constants N_ACT=20, ACT_W=9, CNT_W=5
  - typedefs act_t (signed [ACT_W-1:0]), bitmap_t ([N_ACT-1:0]), idx_t ([CNT_W-1:0])
  - state enum exp_state_t {IDLE, EXPAND}
- One sub-module, sparse_popcount (N-bit to CW-bit count). It is instantiated only under SPARSE_EXP_NNZ_EN and is reusable by the compressor side.

Test Plan:
- Bitmap 20'h00005, nz stream {-7, 100}, out_ready=1:
  - out_data idx0=-7, idx1=0, idx2=100, idx3..19=0
  - out_last only at idx19
  - exactly 2 nz handshakes
- Bitmap 0, nz_valid held high: 20 zero outputs, nz_ready never asserted, first out_valid 1 cycle after header accept.
- Bitmap 20'hFFFFF, nz values 1..20, out_ready toggled 1/0 each cycle:
  - outputs 1..20 in order, none lost or duplicated
  - out_data stable while stalled
- Two headers back-to-back (20'h80000 then 20'h00001, nz {255, -256}):
  - first vector idx19=255
  - second vector idx0=-256
  - exactly one idle cycle between the out_last and the next out_idx=0
- Reset asserted after 7 outputs of an all-ones vector:
  - next cycle out_valid=0, hdr_ready=1
  - new header 20'h00002 with nz {5} yields idx1=5
- With SPARSE_EXP_NNZ_EN:
  - bitmap 20'h0F0F0 gives nnz_count=8
  - consuming an nz value of 0 sets nz_err=1, which stays set until reset

Source files
------------

// File: rtl/sparse_pkg.sv
// sparse_pkg: shared constants, types and state encoding for the sparse activation expander
package sparse_pkg;
  localparam int N_ACT = 20;
  localparam int ACT_W = 9;
  localparam int CNT_W = $clog2(N_ACT + 1);
  typedef logic signed [ACT_W-1:0] act_t;
  typedef logic [N_ACT-1:0] bitmap_t;
  typedef logic [CNT_W-1:0] idx_t;
  typedef enum logic {IDLE, EXPAND} exp_state_t;
endpackage

// File: rtl/sparse_popcount.sv
// sparse_popcount: number of set bits in an N-bit vector, shared with the compressor side
module sparse_popcount
  import sparse_pkg::*;
#(
  parameter int N = N_ACT,
  parameter int CW = CNT_W
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);
  // ripple sum of the set bits
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/sparse_act_expander.sv
// sparse_act_expander: bitmap header + packed nonzero stream to dense activations; SPARSE_EXP_NNZ_EN adds nnz_count and nz_err
module sparse_act_expander
  import sparse_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hdr_valid,
  output logic                    hdr_ready,
  input  logic [N_ACT-1:0]        hdr_bitmap,
  input  logic                    nz_valid,
  output logic                    nz_ready,
  input  logic signed [ACT_W-1:0] nz_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACT_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_idx,
  output logic                    out_last,
`ifdef SPARSE_EXP_NNZ_EN
  output logic [CNT_W-1:0]        nnz_count,
  output logic                    nz_err,
`endif
  output logic                    busy
);
  exp_state_t state, state_nxt;
  idx_t pos;
  bitmap_t bitmap_q;
  logic cur_bit, last_pos, load_en, load;
  // current-position decode and output-register load condition
  always_comb begin
    cur_bit = bitmap_q[pos];
    last_pos = pos == idx_t'(N_ACT - 1);
    load_en = !out_valid || out_ready;
    load = (state == EXPAND) && load_en && (!cur_bit || nz_valid);
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next state: leave IDLE on header, return after the last position loads
  always_comb
    state_nxt = (state == IDLE) ? (hdr_valid ? EXPAND : IDLE) : ((load && last_pos) ? IDLE : EXPAND);
  // handshake outputs; nz is only pulled for set bitmap positions
  always_comb begin
    hdr_ready = (state == IDLE) && !reset;
    nz_ready = (state == EXPAND) && cur_bit && load_en;
    busy = (state == EXPAND) || out_valid;
  end
  // bitmap/position tracking and the registered dense output
  always_ff @(posedge clk)
    if (reset) begin
      pos <= '0;
      bitmap_q <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
    end else begin
      if (hdr_valid && hdr_ready) begin
        bitmap_q <= hdr_bitmap;
        pos <= '0;
      end else if (load) pos <= last_pos ? '0 : pos + 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_data <= cur_bit ? nz_data : '0;
        out_idx <= pos;
        out_last <= last_pos;
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef SPARSE_EXP_NNZ_EN
  logic [CNT_W-1:0] hdr_cnt;
  sparse_popcount #(.N(N_ACT), .CW(CNT_W)) u_pop (.bits(hdr_bitmap), .count(hdr_cnt));
  // latch header popcount; sticky flag for zero values in the packed stream
  always_ff @(posedge clk)
    if (reset) begin
      nnz_count <= '0;
      nz_err <= 1'b0;
    end else begin
      if (hdr_valid && hdr_ready) nnz_count <= hdr_cnt;
      if (nz_valid && nz_ready && nz_data == '0) nz_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sparse_act_expander.sv
// tb_sparse_act_expander: directed self-checking bench for sparse_act_expander
module tb_sparse_act_expander;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hdr_valid = 1'b0;
  logic nz_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [19:0] hdr_bitmap = '0;
  logic signed [8:0] nz_data = '0;
  logic hdr_ready, nz_ready, out_valid, out_last, busy;
  logic signed [8:0] out_data;
  logic [4:0] out_idx;
`ifdef SPARSE_EXP_NNZ_EN
  logic [4:0] nnz_count;
  logic nz_err;
`endif
  int total = 0;
  int bad = 0;
  logic signed [8:0] vals[0:39];
  int nvals;
  logic [19:0] hdrs[0:1];
  int nhdr;
  logic signed [8:0] got_d[0:39];
  logic [4:0] got_i[0:39];
  logic got_l[0:39];
  int got_it[0:39];
  int got_n, nz_hs, nzr_seen, stable_bad, tmo, acc_it, first_it;

  always #5 clk = ~clk;

  sparse_act_expander dut (
    .clk(clk), .reset(reset),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_bitmap(hdr_bitmap),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_data(nz_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
`ifdef SPARSE_EXP_NNZ_EN
    .nnz_count(nnz_count), .nz_err(nz_err),
`endif
    .busy(busy)
  );

  task automatic run(input int rmode, input int stop_n);
    int k = 0;
    int h = 0;
    int it = 0;
    logic held = 1'b0;
    logic signed [8:0] hd = '0;
    logic [4:0] hi = '0;
    got_n = 0; nz_hs = 0; nzr_seen = 0; stable_bad = 0; acc_it = -1; first_it = -1;
    while (got_n < stop_n && it < 400) begin
      hdr_valid = h < nhdr;
      if (h < nhdr) hdr_bitmap = hdrs[h];
      nz_valid = k < nvals;
      if (k < nvals) nz_data = vals[k];
      out_ready = (rmode == 0) || (it % 2 == 0);
      @(negedge clk);
      if (nz_ready) nzr_seen++;
      if (held && (!out_valid || out_data !== hd || out_idx !== hi)) stable_bad++;
      if (out_valid && first_it < 0) first_it = it;
      if (out_valid && out_ready) begin
        got_d[got_n] = out_data; got_i[got_n] = out_idx; got_l[got_n] = out_last; got_it[got_n] = it;
        got_n++;
      end
      held = out_valid && !out_ready; hd = out_data; hi = out_idx;
      if (hdr_valid && hdr_ready) begin
        if (acc_it < 0) acc_it = it;
        h++;
      end
      if (nz_valid && nz_ready) begin
        k++;
        nz_hs++;
      end
      @(posedge clk); #1;
      it++;
    end
    tmo = (got_n < stop_n) ? 1 : 0;
    hdr_valid = 1'b0;
    nz_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (hdr_ready !== 1'b0) begin bad++; $display("FAIL rst_hdr_gate got=%b want=0", hdr_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 9'sd0 || out_idx !== 5'd0 || out_last !== 1'b0) begin bad++; $display("FAIL rst_out_regs got=%0d/%0d/%b want=0/0/0", out_data, out_idx, out_last); end
    total++; if (hdr_ready !== 1'b1) begin bad++; $display("FAIL rst_hdr_ready got=%b want=1", hdr_ready); end
    total++; if (nz_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_nz_busy got=%b/%b want=0/0", nz_ready, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_sparse();
    logic signed [8:0] e;
    nhdr = 1; hdrs[0] = 20'h00005;
    nvals = 2; vals[0] = -9'sd7; vals[1] = 9'sd100;
    run(0, 20);
    total++; if (tmo != 0) begin bad++; $display("FAIL sparse_timeout got=%0d want=20 outputs", got_n); end
    for (int i = 0; i < 20; i++) begin
      e = (i == 0) ? -9'sd7 : (i == 2) ? 9'sd100 : 9'sd0;
      total++; if (got_d[i] !== e || got_i[i] !== 5'(i)) begin bad++; $display("FAIL sparse_elem[%0d] got=%0d@%0d want=%0d@%0d", i, got_d[i], got_i[i], e, i); end
      total++; if (got_l[i] !== (i == 19)) begin bad++; $display("FAIL sparse_last[%0d] got=%b want=%b", i, got_l[i], i == 19); end
    end
    total++; if (nz_hs != 2) begin bad++; $display("FAIL sparse_nz_hs got=%0d want=2", nz_hs); end
  endtask

  task automatic test_all_zero();
    nhdr = 1; hdrs[0] = 20'h00000;
    nvals = 20;
    for (int i = 0; i < 20; i++) vals[i] = 9'sd77;
    run(0, 20);
    total++; if (tmo != 0) begin bad++; $display("FAIL zero_timeout got=%0d want=20 outputs", got_n); end
    for (int i = 0; i < 20; i++) begin
      total++; if (got_d[i] !== 9'sd0 || got_i[i] !== 5'(i)) begin bad++; $display("FAIL zero_elem[%0d] got=%0d@%0d want=0@%0d", i, got_d[i], got_i[i], i); end
    end
    total++; if (nzr_seen != 0 || nz_hs != 0) begin bad++; $display("FAIL zero_nz_ready got=%0d cycles want=0", nzr_seen); end
    total++; if (first_it - acc_it - 1 != 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", first_it - acc_it - 1); end
  endtask

  task automatic test_all_ones_stall();
    nhdr = 1; hdrs[0] = 20'hFFFFF;
    nvals = 20;
    for (int i = 0; i < 20; i++) vals[i] = 9'(i + 1);
    run(1, 20);
    total++; if (tmo != 0) begin bad++; $display("FAIL ones_timeout got=%0d want=20 outputs", got_n); end
    for (int i = 0; i < 20; i++) begin
      total++; if (got_d[i] !== 9'(i + 1) || got_i[i] !== 5'(i)) begin bad++; $display("FAIL ones_elem[%0d] got=%0d@%0d want=%0d@%0d", i, got_d[i], got_i[i], i + 1, i); end
    end
    total++; if (stable_bad != 0) begin bad++; $display("FAIL ones_stable got=%0d changes want=0", stable_bad); end
    total++; if (nz_hs != 20) begin bad++; $display("FAIL ones_nz_hs got=%0d want=20", nz_hs); end
  endtask

  task automatic test_back_to_back();
    logic signed [8:0] e;
    nhdr = 2; hdrs[0] = 20'h80000; hdrs[1] = 20'h00001;
    nvals = 2; vals[0] = 9'sd255; vals[1] = -9'sd256;
    run(0, 40);
    total++; if (tmo != 0) begin bad++; $display("FAIL b2b_timeout got=%0d want=40 outputs", got_n); end
    for (int i = 0; i < 40; i++) begin
      e = (i == 19) ? 9'sd255 : (i == 20) ? -9'sd256 : 9'sd0;
      total++; if (got_d[i] !== e || got_i[i] !== 5'(i % 20)) begin bad++; $display("FAIL b2b_elem[%0d] got=%0d@%0d want=%0d@%0d", i, got_d[i], got_i[i], e, i % 20); end
    end
    total++; if (got_l[19] !== 1'b1 || got_l[39] !== 1'b1) begin bad++; $display("FAIL b2b_last got=%b%b want=11", got_l[19], got_l[39]); end
    total++; if (got_it[20] - got_it[19] != 2) begin bad++; $display("FAIL b2b_bubble got=%0d want=2", got_it[20] - got_it[19]); end
    total++; if (nz_hs != 2) begin bad++; $display("FAIL b2b_nz_hs got=%0d want=2", nz_hs); end
  endtask

  task automatic test_mid_reset();
    logic signed [8:0] e;
    nhdr = 1; hdrs[0] = 20'hFFFFF;
    nvals = 20;
    for (int i = 0; i < 20; i++) vals[i] = 9'(i + 1);
    run(0, 7);
    total++; if (tmo != 0) begin bad++; $display("FAIL mreset_pre got=%0d want=7 outputs", got_n); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nz_valid = 1'b1; nz_data = 9'sd9;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_out_valid got=%b want=0", out_valid); end
    total++; if (hdr_ready !== 1'b1) begin bad++; $display("FAIL mreset_hdr_ready got=%b want=1", hdr_ready); end
    total++; if (nz_ready !== 1'b0) begin bad++; $display("FAIL mreset_nz_ready got=%b want=0", nz_ready); end
    @(posedge clk); #1;
    nz_valid = 1'b0;
    nhdr = 1; hdrs[0] = 20'h00002;
    nvals = 1; vals[0] = 9'sd5;
    run(0, 20);
    total++; if (tmo != 0) begin bad++; $display("FAIL mreset_timeout got=%0d want=20 outputs", got_n); end
    for (int i = 0; i < 20; i++) begin
      e = (i == 1) ? 9'sd5 : 9'sd0;
      total++; if (got_d[i] !== e || got_i[i] !== 5'(i)) begin bad++; $display("FAIL mreset_elem[%0d] got=%0d@%0d want=%0d@%0d", i, got_d[i], got_i[i], e, i); end
    end
    total++; if (nz_hs != 1) begin bad++; $display("FAIL mreset_nz_hs got=%0d want=1", nz_hs); end
  endtask

`ifdef SPARSE_EXP_NNZ_EN
  task automatic test_nnz();
    nhdr = 1; hdrs[0] = 20'h0F0F0;
    nvals = 8;
    for (int i = 0; i < 8; i++) vals[i] = 9'(i + 3);
    run(0, 20);
    total++; if (nnz_count !== 5'd8) begin bad++; $display("FAIL nnz_count got=%0d want=8", nnz_count); end
    total++; if (nz_err !== 1'b0) begin bad++; $display("FAIL nnz_err_clean got=%b want=0", nz_err); end
    nhdr = 1; hdrs[0] = 20'h00001;
    nvals = 1; vals[0] = 9'sd0;
    run(0, 20);
    total++; if (nz_err !== 1'b1) begin bad++; $display("FAIL nnz_err_set got=%b want=1", nz_err); end
    nhdr = 1; hdrs[0] = 20'h00001;
    nvals = 1; vals[0] = 9'sd3;
    run(0, 20);
    total++; if (nz_err !== 1'b1 || nnz_count !== 5'd1) begin bad++; $display("FAIL nnz_err_sticky got=%b/%0d want=1/1", nz_err, nnz_count); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (nz_err !== 1'b0 || nnz_count !== 5'd0) begin bad++; $display("FAIL nnz_reset got=%b/%0d want=0/0", nz_err, nnz_count); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_sparse();
    test_all_zero();
    test_all_ones_stall();
    test_back_to_back();
    test_mid_reset();
`ifdef SPARSE_EXP_NNZ_EN
    test_nnz();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
